// File: rtl/microwave_pkg.sv
// Shared types and constants for the microwave controller.
// Cook states, BCD digit limits and the bcd_time width helper.
package microwave_pkg;
  typedef enum logic [1:0] {
    IDLE,
    COOK,
    PAUSE,
    DONE
  } state_t;

  localparam logic [3:0] DIGIT_MAX  = 4'd9;
  localparam logic [3:0] TENS_MAX   = 4'd5;
  localparam logic [3:0] POWER_FULL = 4'd10;

  function automatic int bcd_width(input int min_digits);
    return 4 * (min_digits + 2);
  endfunction
endpackage

// File: rtl/microwave_if.sv
// Keypad, button, door and display bundle of the microwave controller.
// master drives the panel inputs, slave is the controller side.
interface microwave_if #(
  parameter int MIN_DIGITS = 1
) ();
  import microwave_pkg::*;

  localparam int W = bcd_width(MIN_DIGITS);

  logic         key_valid;
  logic [3:0]   key_code;
  logic         power_sel;
  logic         startn;
  logic         stopn;
  logic         clearn;
  logic         door_closed;
  logic         mag_on;
  logic         running;
  logic         paused;
  logic         done;
  logic [W-1:0] bcd_time;

  modport master (
    output key_valid, key_code, power_sel,
    output startn, stopn, clearn, door_closed,
    input  mag_on, running, paused, done, bcd_time
  );

  modport slave (
    input  key_valid, key_code, power_sel,
    input  startn, stopn, clearn, door_closed,
    output mag_on, running, paused, done, bcd_time
  );
endinterface

// File: rtl/bcd_down_counter.sv
// mm:ss BCD register: keypad shift-in, clear and one-second decrement.
// Seconds borrow as 0 -> 59; an entered tens digit above 5 counts down as-is.
module bcd_down_counter #(
  parameter int N = 1
) (
  input  logic             clock,
  input  logic             resetn,
  input  logic             load,
  input  logic [3:0]       digit,
  input  logic             dec,
  input  logic             clear,
  output logic [4*N+7:0]   value,
  output logic             zero_next
);
  import microwave_pkg::*;

  localparam int D = N + 2;

  logic [4*D-1:0] dec_val;
  logic           borrow;

  always_comb begin
    dec_val = value;
    borrow  = 1'b0;
    if (value[3:0] != 4'd0) begin
      dec_val[3:0] = value[3:0] - 4'd1;
    end else if (value[7:4] != 4'd0) begin
      dec_val[3:0] = DIGIT_MAX;
      dec_val[7:4] = value[7:4] - 4'd1;
    end else begin
      dec_val[3:0] = DIGIT_MAX;
      dec_val[7:4] = TENS_MAX;
      borrow       = 1'b1;
      for (int i = 2; i < D; i++) begin
        if (borrow) begin
          if (value[4*i+:4] != 4'd0) begin
            dec_val[4*i+:4] = value[4*i+:4] - 4'd1;
            borrow          = 1'b0;
          end else begin
            dec_val[4*i+:4] = DIGIT_MAX;
          end
        end
      end
    end
  end

  assign zero_next = (dec_val == '0);

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      value <= '0;
    end else if (clear) begin
      value <= '0;
    end else if (load) begin
      value <= {value[4*D-5:0], digit};
    end else if (dec) begin
      value <= dec_val;
    end
  end
endmodule

// File: rtl/microwave_core.sv
// Microwave controller: tick prescaler, digit entry, mm:ss countdown, cook FSM.
// MICROWAVE_POWER_LEVEL_EN adds a keypad power level with a 10-tick duty window.
module microwave_core #(
  parameter int CLK_DIV    = 1000,
  parameter int MIN_DIGITS = 1,
  parameter int DONE_SEC   = 3
) (
  input logic        clock,
  input logic        resetn,
  microwave_if.slave bus
);
  import microwave_pkg::*;

  localparam int W  = bcd_width(MIN_DIGITS);
  localparam int PW = $clog2(CLK_DIV);
  localparam int DW = $clog2(DONE_SEC + 1);
  localparam logic [PW-1:0] PS_MAX    = PW'(CLK_DIV - 1);
  localparam logic [DW-1:0] DONE_LAST = DW'(DONE_SEC - 1);

  state_t        state, state_n;
  logic [PW-1:0] ps, ps_n;
  logic [DW-1:0] dcnt, dcnt_n;
  logic          start_prev, stop_prev;
  logic          start_edge, stop_edge;
  logic          clr, tick, sel_power;
  logic          key_digit, key_free;
  logic          cnt_clear, cnt_load, cnt_dec;
  logic          zero_next, time_zero;
  logic          power_gate;
  logic [W-1:0]  value;

  assign start_edge = start_prev & ~bus.startn;
  assign stop_edge  = stop_prev & ~bus.stopn;
  assign clr        = ~bus.clearn;
  assign tick       = (ps == PS_MAX);
  assign time_zero  = (value == '0);
  assign key_free   = ~stop_edge & ~start_edge;
  assign key_digit  = bus.key_valid & ~sel_power
                    & (bus.key_code <= DIGIT_MAX);

  bcd_down_counter #(.N(MIN_DIGITS)) u_cnt (
    .clock     (clock),
    .resetn    (resetn),
    .load      (cnt_load),
    .digit     (bus.key_code),
    .dec       (cnt_dec),
    .clear     (cnt_clear),
    .value     (value),
    .zero_next (zero_next)
  );

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state      <= IDLE;
      ps         <= '0;
      dcnt       <= '0;
      start_prev <= 1'b1;
      stop_prev  <= 1'b1;
    end else begin
      state      <= state_n;
      ps         <= ps_n;
      dcnt       <= dcnt_n;
      start_prev <= bus.startn;
      stop_prev  <= bus.stopn;
    end
  end

  always_comb begin
    state_n   = state;
    ps_n      = ps;
    dcnt_n    = dcnt;
    cnt_clear = 1'b0;
    cnt_load  = 1'b0;
    cnt_dec   = 1'b0;
    if (clr) begin
      state_n   = IDLE;
      ps_n      = '0;
      cnt_clear = 1'b1;
    end else begin
      unique case (state)
        IDLE: begin
          if (~stop_edge & start_edge & bus.door_closed & ~time_zero) begin
            state_n = COOK;
            ps_n    = '0;
          end else if (key_free & key_digit) begin
            cnt_load = 1'b1;
          end
        end
        COOK: begin
          if (stop_edge | ~bus.door_closed) begin
            state_n = PAUSE;
          end else begin
            ps_n = tick ? '0 : ps + 1'b1;
            if (tick) begin
              cnt_dec = 1'b1;
              if (zero_next) begin
                state_n = DONE;
                dcnt_n  = '0;
              end
            end
          end
        end
        PAUSE: begin
          if (stop_edge) begin
            state_n   = IDLE;
            cnt_clear = 1'b1;
          end else if (start_edge & bus.door_closed) begin
            state_n = COOK;
          end
        end
        DONE: begin
          if (start_edge | stop_edge | bus.key_valid) begin
            state_n = IDLE;
          end else begin
            ps_n = tick ? '0 : ps + 1'b1;
            if (tick) begin
              if (dcnt == DONE_LAST) state_n = IDLE;
              else dcnt_n = dcnt + 1'b1;
            end
          end
        end
        default: state_n = IDLE;
      endcase
    end
  end

`ifdef MICROWAVE_POWER_LEVEL_EN
  logic [3:0] power, power_n;
  logic [3:0] window, window_n;

  assign sel_power = bus.power_sel;

  always_comb begin
    power_n  = power;
    window_n = window;
    if (clr) begin
      power_n = POWER_FULL;
    end else if (bus.key_valid & sel_power & key_free
                 & (bus.key_code <= DIGIT_MAX)
                 & ((state == IDLE) | (state == PAUSE))) begin
      power_n = (bus.key_code == 4'd0) ? POWER_FULL : bus.key_code;
    end
    // window restarts only on a fresh cook, a resume keeps its phase
    if ((state == IDLE) & (state_n == COOK)) begin
      window_n = '0;
    end else if (cnt_dec) begin
      window_n = (window == DIGIT_MAX) ? 4'd0 : window + 4'd1;
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      power  <= POWER_FULL;
      window <= '0;
    end else begin
      power  <= power_n;
      window <= window_n;
    end
  end

  assign power_gate = (window < power);
`else
  logic unused_power_sel;

  assign sel_power        = 1'b0;
  assign power_gate       = 1'b1;
  assign unused_power_sel = bus.power_sel;
`endif

  assign bus.running  = (state == COOK);
  assign bus.paused   = (state == PAUSE);
  assign bus.done     = (state == DONE);
  assign bus.bcd_time = value;
  assign bus.mag_on   = (state == COOK) & bus.door_closed & power_gate;
endmodule

// File: tb/tb_microwave_core.sv
// Bench for microwave_core: vector table, directed corner sequences and
// random stimulus against a digit-level behavioural model.
module tb_microwave_core;
  localparam int CLK_DIV    = 4;
  localparam int MIN_DIGITS = 1;
  localparam int DONE_SEC   = 3;
  localparam int ND         = MIN_DIGITS + 2;
  localparam int W          = 4 * ND;

  logic clock = 1'b0;
  logic resetn;
  int   checks   = 0;
  int   failures = 0;

  always #5 clock = ~clock;

  microwave_if #(.MIN_DIGITS(MIN_DIGITS)) bus ();

  microwave_core #(
    .CLK_DIV    (CLK_DIV),
    .MIN_DIGITS (MIN_DIGITS),
    .DONE_SEC   (DONE_SEC)
  ) dut (
    .clock  (clock),
    .resetn (resetn),
    .bus    (bus.slave)
  );

  // model: 0 idle, 1 cook, 2 pause, 3 done; digits[0] = seconds ones
  int m_st;
  int m_d[ND];
  int m_ps;
  int m_dc;
  bit m_sp;
  bit m_tp;

  function automatic bit m_zero();
    for (int i = 0; i < ND; i++) if (m_d[i] != 0) return 1'b0;
    return 1'b1;
  endfunction

  function automatic logic [W-1:0] m_bcd();
    logic [W-1:0] r;
    r = '0;
    for (int i = 0; i < ND; i++) r[4*i+:4] = 4'(m_d[i]);
    return r;
  endfunction

  task automatic m_clear();
    for (int i = 0; i < ND; i++) m_d[i] = 0;
  endtask

  task automatic m_dec();
    int mins;
    if (m_d[0] > 0) begin
      m_d[0]--;
    end else if (m_d[1] > 0) begin
      m_d[0] = 9;
      m_d[1]--;
    end else begin
      mins = 0;
      for (int i = ND - 1; i >= 2; i--) mins = mins * 10 + m_d[i];
      mins = mins - 1;
      m_d[0] = 9;
      m_d[1] = 5;
      for (int i = 2; i < ND; i++) begin
        m_d[i] = mins % 10;
        mins   = mins / 10;
      end
    end
  endtask

  task automatic model_reset();
    m_st = 0;
    m_ps = 0;
    m_dc = 0;
    m_sp = 1'b1;
    m_tp = 1'b1;
    m_clear();
  endtask

  task automatic model_step();
    bit se, te, kd, tk;
    se = m_sp && !bus.startn;
    te = m_tp && !bus.stopn;
    m_sp = bus.startn;
    m_tp = bus.stopn;
    kd = bus.key_valid && (bus.key_code <= 4'd9);
`ifdef MICROWAVE_POWER_LEVEL_EN
    if (bus.power_sel) kd = 1'b0;
`endif
    tk = (m_ps == CLK_DIV - 1);
    if (!bus.clearn) begin
      m_st = 0;
      m_ps = 0;
      m_clear();
    end else begin
      case (m_st)
        0: begin
          if (!te && se) begin
            if (bus.door_closed && !m_zero()) begin
              m_st = 1;
              m_ps = 0;
            end
          end else if (!te && !se && kd) begin
            for (int i = ND - 1; i > 0; i--) m_d[i] = m_d[i-1];
            m_d[0] = int'(bus.key_code);
          end
        end
        1: begin
          if (te || !bus.door_closed) m_st = 2;
          else if (tk) begin
            m_ps = 0;
            m_dec();
            if (m_zero()) begin
              m_st = 3;
              m_dc = 0;
            end
          end else m_ps++;
        end
        2: begin
          if (te) begin
            m_st = 0;
            m_clear();
          end else if (se && bus.door_closed) m_st = 1;
        end
        default: begin
          if (se || te || bus.key_valid) m_st = 0;
          else if (tk) begin
            m_ps = 0;
            m_dc++;
            if (m_dc == DONE_SEC) m_st = 0;
          end else m_ps++;
        end
      endcase
    end
  endtask

  task automatic step();
    @(posedge clock);
    model_step();
    @(negedge clock);
  endtask

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic key(input logic [3:0] c, input logic sel);
    bus.key_valid = 1'b1;
    bus.key_code  = c;
    bus.power_sel = sel;
    step();
    bus.key_valid = 1'b0;
    bus.power_sel = 1'b0;
  endtask

  task automatic press_start();
    bus.startn = 1'b0;
    step();
    bus.startn = 1'b1;
  endtask

  typedef struct {
    logic         kv;
    logic [3:0]   kc;
    logic         st;
    logic         dr;
    logic [W-1:0] bcd;
    logic         run;
    logic         mag;
  } vec_t;

  vec_t tbl[11];

  initial begin
    int n;
    logic [W+3:0] exp_v, act_v;

    tbl[0]  = '{1'b1, 4'd1,  1'b1, 1'b1, 12'h001, 1'b0, 1'b0};
    tbl[1]  = '{1'b1, 4'd0,  1'b1, 1'b1, 12'h010, 1'b0, 1'b0};
    tbl[2]  = '{1'b1, 4'd12, 1'b1, 1'b1, 12'h010, 1'b0, 1'b0};
    tbl[3]  = '{1'b1, 4'd5,  1'b1, 1'b1, 12'h105, 1'b0, 1'b0};
    tbl[4]  = '{1'b0, 4'd0,  1'b0, 1'b0, 12'h105, 1'b0, 1'b0};
    tbl[5]  = '{1'b0, 4'd0,  1'b1, 1'b1, 12'h105, 1'b0, 1'b0};
    tbl[6]  = '{1'b0, 4'd0,  1'b0, 1'b1, 12'h105, 1'b1, 1'b1};
    tbl[7]  = '{1'b1, 4'd3,  1'b0, 1'b1, 12'h105, 1'b1, 1'b1};
    tbl[8]  = '{1'b0, 4'd0,  1'b1, 1'b1, 12'h105, 1'b1, 1'b1};
    tbl[9]  = '{1'b0, 4'd0,  1'b1, 1'b1, 12'h105, 1'b1, 1'b1};
    tbl[10] = '{1'b0, 4'd0,  1'b1, 1'b1, 12'h104, 1'b1, 1'b1};

    resetn          = 1'b0;
    bus.key_valid   = 1'b0;
    bus.key_code    = 4'd0;
    bus.power_sel   = 1'b0;
    bus.startn      = 1'b1;
    bus.stopn       = 1'b1;
    bus.clearn      = 1'b1;
    bus.door_closed = 1'b1;
    model_reset();
    repeat (2) @(negedge clock);
    resetn = 1'b1;
    chk("reset_state", {bus.mag_on, bus.running, bus.paused, bus.done},
        32'h0);
    chk("reset_bcd", bus.bcd_time, 32'h0);

    for (int i = 0; i < 11; i++) begin
      bus.key_valid   = tbl[i].kv;
      bus.key_code    = tbl[i].kc;
      bus.startn      = tbl[i].st;
      bus.door_closed = tbl[i].dr;
      step();
      chk($sformatf("vec%0d_bcd", i), bus.bcd_time, tbl[i].bcd);
      chk($sformatf("vec%0d_run", i), bus.running, tbl[i].run);
      chk($sformatf("vec%0d_mag", i), bus.mag_on, tbl[i].mag);
    end
    bus.key_valid = 1'b0;

    repeat (16) step();
    chk("cook_1_00", bus.bcd_time, 32'h100);
    repeat (4) step();
    chk("borrow_0_59", bus.bcd_time, 32'h059);

    // clear beats a simultaneous start edge and key
    bus.clearn    = 1'b0;
    bus.startn    = 1'b0;
    bus.key_valid = 1'b1;
    bus.key_code  = 4'd7;
    step();
    chk("clear_bcd", bus.bcd_time, 32'h0);
    chk("clear_run", bus.running, 32'h0);
    bus.clearn    = 1'b1;
    bus.startn    = 1'b1;
    bus.key_valid = 1'b0;
    step();

    key(4'd0, 1'b0);
    key(4'd9, 1'b0);
    key(4'd0, 1'b0);
    chk("entry_0_90", bus.bcd_time, 32'h090);
    press_start();
    repeat (4) step();
    chk("tens_over_5", bus.bcd_time, 32'h089);
    n = 0;
    while (!bus.done && n < 600) begin
      step();
      n++;
    end
    chk("done_reached", bus.done, 32'h1);
    chk("done_bcd", bus.bcd_time, 32'h0);
    chk("done_mag", bus.mag_on, 32'h0);
    n = 0;
    while (bus.done && n < 100) begin
      n++;
      step();
    end
    chk("done_len", n, DONE_SEC * CLK_DIV);
    chk("done_idle", {bus.running, bus.paused, bus.done}, 32'h0);

    key(4'd3, 1'b0);
    key(4'd0, 1'b0);
    press_start();
    repeat (6) step();
    chk("pre_door_bcd", bus.bcd_time, 32'h029);
    bus.door_closed = 1'b0;
    #1;
    chk("door_mag_now", bus.mag_on, 32'h0);
    chk("door_run_now", bus.running, 32'h1);
    step();
    chk("door_paused", bus.paused, 32'h1);
    repeat (3) step();
    chk("pause_hold", bus.bcd_time, 32'h029);
    bus.door_closed = 1'b1;
    step();
    press_start();
    chk("resume_run", bus.running, 32'h1);
    step();
    chk("resume_phase_a", bus.bcd_time, 32'h029);
    step();
    chk("resume_phase_b", bus.bcd_time, 32'h028);

    bus.stopn = 1'b0;
    step();
    chk("stop_pause", bus.paused, 32'h1);
    bus.stopn = 1'b1;
    step();
    bus.stopn = 1'b0;
    step();
    chk("stop_idle", {bus.running, bus.paused, bus.bcd_time}, 32'h0);
    bus.stopn = 1'b1;
    step();
    press_start();
    chk("start_zero", bus.running, 32'h0);
    key(4'd5, 1'b0);
    bus.door_closed = 1'b0;
    press_start();
    chk("start_door_open", {bus.running, bus.bcd_time}, 32'h005);
    bus.door_closed = 1'b1;
    step();

    press_start();
    repeat (2) step();
    #2 resetn = 1'b0;
    #1;
    chk("async_reset",
        {bus.mag_on, bus.running, bus.paused, bus.done, bus.bcd_time}, 32'h0);
    model_reset();
    @(negedge clock);
    resetn = 1'b1;

    key(4'd3, 1'b1);
    key(4'd0, 1'b0);
    key(4'd2, 1'b0);
    key(4'd0, 1'b0);
    chk("power_entry", bus.bcd_time, 32'h020);
    press_start();
    for (int k = 0; k < 10; k++) begin
`ifdef MICROWAVE_POWER_LEVEL_EN
      chk($sformatf("power_win%0d", k), bus.mag_on, (k < 3) ? 32'h1 : 32'h0);
`else
      chk($sformatf("power_win%0d", k), bus.mag_on, 32'h1);
`endif
      repeat (CLK_DIV) step();
    end
    bus.clearn = 1'b0;
    step();
    bus.clearn = 1'b1;
    step();

    for (int c = 0; c < 3000; c++) begin
      bus.key_valid   = ($urandom_range(0, 3) == 0);
      bus.key_code    = 4'($urandom_range(0, 15));
      bus.power_sel   = 1'b0;
      bus.startn      = ($urandom_range(0, 3) != 0);
      bus.stopn       = ($urandom_range(0, 19) != 0);
      bus.clearn      = ($urandom_range(0, 49) != 0);
      bus.door_closed = ($urandom_range(0, 14) != 0);
      step();
      exp_v = {(m_st == 1) && bus.door_closed, m_st == 1, m_st == 2,
               m_st == 3, m_bcd()};
      act_v = {bus.mag_on, bus.running, bus.paused, bus.done, bus.bcd_time};
      chk($sformatf("random%0d", c), act_v, exp_v);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
